// File: rtl/attack_scheduler_if.sv
// rtl/attack_scheduler_if.sv - player/attack-unit signal bundle for the attack scheduler
interface attack_scheduler_if;
  logic [1:0] fire_req;
  logic [1:0] reload_req;
  logic [4:0] aim0;
  logic [4:0] aim1;
  logic [4:0] pos0;
  logic [4:0] pos1;
  logic [5:0] atk_damage;
  logic       atk_en;
  logic       atk_rst_n;
  logic [4:0] atk_aim;
  logic [4:0] atk_dodge;
  logic [6:0] hp0;
  logic [6:0] hp1;
  logic [3:0] ammo0;
  logic [3:0] ammo1;
  logic [1:0] reloading;
  logic [1:0] fire_nack;
  logic       shot_done;
  logic       shot_src;
  logic [5:0] shot_dmg;
  logic       game_over;
  logic       winner;

  modport master (
    output fire_req, reload_req, aim0, aim1, pos0, pos1, atk_damage,
    input  atk_en, atk_rst_n, atk_aim, atk_dodge, hp0, hp1, ammo0, ammo1,
           reloading, fire_nack, shot_done, shot_src, shot_dmg, game_over, winner
  );

  modport slave (
    input  fire_req, reload_req, aim0, aim1, pos0, pos1, atk_damage,
    output atk_en, atk_rst_n, atk_aim, atk_dodge, hp0, hp1, ammo0, ammo1,
           reloading, fire_nack, shot_done, shot_src, shot_dmg, game_over, winner
  );
endinterface

// File: rtl/attack_scheduler.sv
// rtl/attack_scheduler.sv - two-player round-robin shot scheduler owning ammo, reload and hp
module attack_scheduler #(
  parameter int CLIP       = 15,
  parameter int RELOAD_CYC = 20,
  parameter int HP_MAX     = 100
) (
  input  logic             clk,
  input  logic             rst,
  attack_scheduler_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_APPLY  = 3'd2;
  localparam logic [2:0] S_REFILL = 3'd3;
  localparam logic [2:0] S_OVER   = 3'd4;
  localparam int CW = $clog2(RELOAD_CYC);

  logic [2:0]          state_q, state_d;
  logic [1:0][6:0]     hp_q, hp_d;
  logic [1:0][3:0]     ammo_q, ammo_d;
  logic [1:0][CW-1:0]  rcnt_q, rcnt_d;
  logic [1:0]          reloading_q, reloading_d;
  logic                rr_q, rr_d;
  logic                shooter_q, shooter_d;
  logic [1:0]          nack_q, nack_d;
  logic                shot_done_q, shot_done_d;
  logic                shot_src_q, shot_src_d;
  logic [5:0]          shot_dmg_q, shot_dmg_d;

  logic [1:0] eligible;
  logic       gnt;
  logic       target;
  logic [6:0] hp_tgt;
  logic [6:0] hp_new;
  logic       issuing;

  // A same-cycle reload request blocks the fire request for that player.
  assign eligible = bus.fire_req & ~reloading_q & ~bus.reload_req;
  assign target   = ~shooter_q;
  assign hp_tgt   = hp_q[target];
  assign hp_new   = (hp_tgt > {1'b0, bus.atk_damage}) ? hp_tgt - {1'b0, bus.atk_damage} : 7'd0;

  always_comb begin
    state_d     = state_q;
    hp_d        = hp_q;
    ammo_d      = ammo_q;
    rcnt_d      = rcnt_q;
    reloading_d = reloading_q;
    rr_d        = rr_q;
    shooter_d   = shooter_q;
    nack_d      = 2'b00;
    shot_done_d = 1'b0;
    shot_src_d  = shot_src_q;
    shot_dmg_d  = shot_dmg_q;
    gnt         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (eligible != 2'b00) begin
          gnt = (eligible == 2'b11) ? rr_q : eligible[1];
          if (ammo_q[gnt] == 4'd0) begin
            nack_d[gnt] = 1'b1;
          end else begin
            shooter_d   = gnt;
            ammo_d[gnt] = ammo_q[gnt] - 4'd1;
            rr_d        = ~gnt;
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE:  state_d = S_APPLY;
      S_APPLY: begin
        hp_d[target] = hp_new;
        shot_done_d  = 1'b1;
        shot_src_d   = shooter_q;
        shot_dmg_d   = bus.atk_damage;
        state_d      = (hp_new == 7'd0) ? S_OVER : S_REFILL;
      end
      S_REFILL: state_d = S_IDLE;
      S_OVER:   state_d = S_OVER;
      default:  state_d = S_IDLE;
    endcase

    // Reload timers are independent of the shot sequence; a reloading player is never granted.
    for (int p = 0; p < 2; p++) begin
      if (reloading_q[p]) begin
        if (rcnt_q[p] == '0) begin
          reloading_d[p] = 1'b0;
          ammo_d[p]      = 4'(CLIP);
        end else begin
          rcnt_d[p] = rcnt_q[p] - 1'b1;
        end
      end else if (bus.reload_req[p] && ammo_q[p] != 4'(CLIP) && state_q != S_OVER) begin
        reloading_d[p] = 1'b1;
        rcnt_d[p]      = CW'(RELOAD_CYC - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      hp_q        <= {2{7'(HP_MAX)}};
      ammo_q      <= {2{4'(CLIP)}};
      rcnt_q      <= '0;
      reloading_q <= 2'b00;
      rr_q        <= 1'b0;
      shooter_q   <= 1'b0;
      nack_q      <= 2'b00;
      shot_done_q <= 1'b0;
      shot_src_q  <= 1'b0;
      shot_dmg_q  <= 6'd0;
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      ammo_q      <= ammo_d;
      rcnt_q      <= rcnt_d;
      reloading_q <= reloading_d;
      rr_q        <= rr_d;
      shooter_q   <= shooter_d;
      nack_q      <= nack_d;
      shot_done_q <= shot_done_d;
      shot_src_q  <= shot_src_d;
      shot_dmg_q  <= shot_dmg_d;
    end
  end

  assign issuing       = (state_q == S_ISSUE);
  assign bus.atk_en    = issuing;
  assign bus.atk_rst_n = rst && (state_q != S_REFILL);
  assign bus.atk_aim   = issuing ? (shooter_q ? bus.aim1 : bus.aim0) : 5'd0;
  assign bus.atk_dodge = issuing ? (shooter_q ? bus.pos0 : bus.pos1) : 5'd0;
  assign bus.hp0       = hp_q[0];
  assign bus.hp1       = hp_q[1];
  assign bus.ammo0     = ammo_q[0];
  assign bus.ammo1     = ammo_q[1];
  assign bus.reloading = reloading_q;
  assign bus.fire_nack = nack_q;
  assign bus.shot_done = shot_done_q;
  assign bus.shot_src  = shot_src_q;
  assign bus.shot_dmg  = shot_dmg_q;
  assign bus.game_over = (state_q == S_OVER);
  assign bus.winner    = (state_q == S_OVER) && shooter_q;
endmodule

// File: tb/tb_attack_scheduler.sv
// tb/tb_attack_scheduler.sv - directed bench with a shot-timeline reference model for attack_scheduler
module tb_attack_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  attack_scheduler_if bus ();
  attack_scheduler dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each shot is a timeline (grant, then 1 issue, 1 apply, 1 refill cycle);
  // reloads are a countdown of remaining busy cycles.
  int  m_hp[2];
  int  m_ammo[2];
  int  m_rl[2];
  int  m_age;
  bit  m_over, m_rr, m_shooter, m_done, m_src;
  int  m_dmg;
  bit  [1:0] m_nack;
  bit  el[2];
  bit  g;
  int  t;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hp = '{100, 100}; m_ammo = '{15, 15}; m_rl = '{0, 0};
      m_age = -1; m_over = 0; m_rr = 0; m_shooter = 0;
      m_done = 0; m_src = 0; m_dmg = 0; m_nack = 0;
    end else begin
      for (int p = 0; p < 2; p++)
        el[p] = bus.fire_req[p] && (m_rl[p] == 0) && !bus.reload_req[p];
      m_nack = 0;
      m_done = 0;
      for (int p = 0; p < 2; p++) begin
        if (m_rl[p] > 0) begin
          m_rl[p]--;
          if (m_rl[p] == 0) m_ammo[p] = 15;
        end else if (bus.reload_req[p] && m_ammo[p] != 15 && !m_over) begin
          m_rl[p] = 20;
        end
      end
      if (!m_over) begin
        if (m_age < 0) begin
          if (el[0] || el[1]) begin
            g = (el[0] && el[1]) ? m_rr : el[1];
            if (m_ammo[g] == 0) m_nack[g] = 1;
            else begin
              m_ammo[g]--; m_shooter = g; m_rr = !g; m_age = 0;
            end
          end
        end else if (m_age == 0) begin
          m_age = 1;
        end else if (m_age == 1) begin
          t = m_hp[!m_shooter] - int'(bus.atk_damage);
          m_hp[!m_shooter] = (t < 0) ? 0 : t;
          m_done = 1; m_src = m_shooter; m_dmg = bus.atk_damage;
          if (m_hp[!m_shooter] == 0) begin m_over = 1; m_age = -1; end
          else m_age = 2;
        end else begin
          m_age = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("hp0", bus.hp0, m_hp[0]);
      chk("hp1", bus.hp1, m_hp[1]);
      chk("ammo0", bus.ammo0, m_ammo[0]);
      chk("ammo1", bus.ammo1, m_ammo[1]);
      chk("reloading", bus.reloading, {m_rl[1] > 0, m_rl[0] > 0});
      chk("fire_nack", bus.fire_nack, m_nack);
      chk("shot_done", bus.shot_done, m_done);
      chk("shot_src", bus.shot_src, m_src);
      chk("shot_dmg", bus.shot_dmg, m_dmg);
      chk("game_over", bus.game_over, m_over);
      chk("winner", bus.winner, m_over & m_shooter);
      chk("atk_en", bus.atk_en, m_age == 0);
      chk("atk_rst_n", bus.atk_rst_n, rst && (m_age != 2));
      chk("atk_aim", bus.atk_aim, (m_age == 0) ? (m_shooter ? bus.aim1 : bus.aim0) : 5'd0);
      chk("atk_dodge", bus.atk_dodge, (m_age == 0) ? (m_shooter ? bus.pos0 : bus.pos1) : 5'd0);
    end
  end

  int en_cnt, rstn_low_cnt, done_cnt, nack_cnt, rel_cnt;
  logic [3:0] seq;
  always @(negedge clk) begin
    if (rst) begin
      if (bus.atk_en) en_cnt++;
      if (!bus.atk_rst_n) rstn_low_cnt++;
      if (bus.shot_done) begin done_cnt++; seq = {seq[2:0], bus.shot_src}; end
      if (|bus.fire_nack) nack_cnt++;
      if (bus.reloading[0]) rel_cnt++;
    end
  end

  task automatic clr();
    en_cnt = 0; rstn_low_cnt = 0; done_cnt = 0; nack_cnt = 0; rel_cnt = 0; seq = 4'd0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.fire_req = 0; bus.reload_req = 0; bus.atk_damage = 0;
    bus.aim0 = 5'd3; bus.aim1 = 5'd7; bus.pos0 = 5'd12; bus.pos1 = 5'd10;
    step(2);
    rst = 1'b1;
    clr();
  endtask

  bit found;

  initial begin
    do_reset();
    cmp_en = 1'b1;
    chk("rst_hp0", bus.hp0, 100);
    chk("rst_ammo1", bus.ammo1, 15);
    chk("rst_go", bus.game_over, 0);

    // single shot by player 0
    bus.aim0 = 5'd10; bus.pos1 = 5'd10; bus.atk_damage = 6'd36; bus.fire_req = 2'b01;
    step(1);
    bus.fire_req = 2'b00;
    step(8);
    chk("t1_hp1", bus.hp1, 64);
    chk("t1_ammo0", bus.ammo0, 14);
    chk("t1_en_cycles", en_cnt, 1);
    chk("t1_rstn_low", rstn_low_cnt, 1);
    chk("t1_done", done_cnt, 1);
    chk("t1_dmg", bus.shot_dmg, 36);

    // both fire continuously: alternate grants
    do_reset();
    bus.atk_damage = 6'd1; bus.fire_req = 2'b11;
    step(16);
    bus.fire_req = 2'b00;
    step(6);
    chk("t2_shots", done_cnt, 4);
    chk("t2_order", seq, 4'b0101);
    chk("t2_hp0", bus.hp0, 98);
    chk("t2_hp1", bus.hp1, 98);

    // empty the clip, nack, then reload
    do_reset();
    bus.atk_damage = 6'd2; bus.fire_req = 2'b01;
    step(70);
    bus.fire_req = 2'b00;
    step(2);
    chk("t3_en_cycles", en_cnt, 15);
    chk("t3_ammo0", bus.ammo0, 0);
    chk("t3_hp1", bus.hp1, 70);
    chk("t3_nacks", nack_cnt, 10);
    clr();
    bus.reload_req = 2'b01;
    step(1);
    bus.reload_req = 2'b00;
    step(25);
    chk("t3_reload_cycles", rel_cnt, 20);
    chk("t3_ammo0_full", bus.ammo0, 15);

    // lethal shot saturates at zero and ends the game
    do_reset();
    bus.atk_damage = 6'd40; bus.fire_req = 2'b01;
    step(8);
    bus.fire_req = 2'b00;
    step(4);
    chk("t4_hp1_pre", bus.hp1, 20);
    bus.atk_damage = 6'd36; bus.fire_req = 2'b01;
    step(1);
    bus.fire_req = 2'b00;
    step(5);
    chk("t4_hp1", bus.hp1, 0);
    chk("t4_go", bus.game_over, 1);
    chk("t4_winner", bus.winner, 0);
    clr();
    bus.fire_req = 2'b11; bus.reload_req = 2'b01;
    step(20);
    bus.fire_req = 2'b00; bus.reload_req = 2'b00;
    chk("t4_no_en", en_cnt, 0);
    chk("t4_no_reload", bus.reloading, 0);
    chk("t4_ammo0", bus.ammo0, 12);
    chk("t4_go_sticky", bus.game_over, 1);

    // reload wins a same-cycle fire request
    do_reset();
    bus.atk_damage = 6'd0; bus.fire_req = 2'b01;
    step(40);
    bus.fire_req = 2'b00;
    step(4);
    chk("t5_ammo0_pre", bus.ammo0, 5);
    clr();
    bus.fire_req = 2'b01; bus.reload_req = 2'b01;
    step(1);
    chk("t5_reloading", bus.reloading, 2'b01);
    bus.fire_req = 2'b00; bus.reload_req = 2'b00;
    step(4);
    chk("t5_no_en", en_cnt, 0);
    chk("t5_ammo0", bus.ammo0, 5);

    // asynchronous reset in the middle of a shot
    do_reset();
    bus.atk_damage = 6'd50; bus.fire_req = 2'b10;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.atk_en) found = 1'b1;
    end
    chk("t6_issue_seen", found, 1);
    #1 rst = 1'b0;
    #1;
    chk("t6_en", bus.atk_en, 0);
    chk("t6_rstn", bus.atk_rst_n, 0);
    chk("t6_hp0", bus.hp0, 100);
    chk("t6_ammo1", bus.ammo1, 15);
    chk("t6_done", bus.shot_done, 0);
    bus.fire_req = 2'b00;
    step(2);
    rst = 1'b1;
    step(4);
    chk("t6_hp0_after", bus.hp0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
